// File: rtl/bde_arb_pkg.sv
// Shared types and constants for the bitmap-engine read-port arbiter.
// Round-robin arbitration is selected by defining BDE_RD_ARB_RR_EN.
package bde_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 8;

  localparam logic REQ_DISP = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

endpackage

// File: rtl/bde_arb_pick.sv
// Combinational winner select for the two read requesters.
// BDE_RD_ARB_RR_EN: round-robin on collision; otherwise fixed priority r0 > r1.
module bde_arb_pick
  import bde_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_any,
  output logic       o_win
);

  assign o_any = |i_req;

`ifdef BDE_RD_ARB_RR_EN
  // On a collision the requester that did not own the last burst wins.
  always_comb begin
    o_win = REQ_DISP;
    if (i_req == 2'b11) begin
      o_win = ~i_last_owner;
    end else if (i_req[1]) begin
      o_win = REQ_AUX;
    end
  end
`else
  logic w_unused;
  assign w_unused = i_last_owner;

  always_comb begin
    o_win = REQ_DISP;
    if (!i_req[0] && i_req[1]) begin
      o_win = REQ_AUX;
    end
  end
`endif

endmodule

// File: rtl/bde_rd_arbiter.sv
// Two-requester arbiter for the single bitmap-engine AXI read port; one burst in flight.
// BDE_RD_ARB_RR_EN selects round-robin arbitration instead of fixed r0 > r1 priority.
module bde_rd_arbiter
  import bde_arb_pkg::*;
#(
  parameter int C_ADDR_WIDTH = ADDR_W_DEF,
  parameter int C_DATA_WIDTH = DATA_W_DEF,
  parameter int C_LEN_WIDTH  = LEN_W_DEF
) (
  input  logic                    clk_axi,
  input  logic                    reset_axi,
  input  logic                    r0_req,
  output logic                    r0_ack,
  input  logic [C_LEN_WIDTH-1:0]  r0_arlen,
  input  logic [C_ADDR_WIDTH-1:0] r0_address,
  output logic [C_DATA_WIDTH-1:0] r0_data,
  output logic                    r0_data_valid,
  input  logic                    r1_req,
  output logic                    r1_ack,
  input  logic [C_LEN_WIDTH-1:0]  r1_arlen,
  input  logic [C_ADDR_WIDTH-1:0] r1_address,
  output logic [C_DATA_WIDTH-1:0] r1_data,
  output logic                    r1_data_valid,
  output logic                    m_req,
  input  logic                    m_ack,
  output logic [C_LEN_WIDTH-1:0]  m_arlen,
  output logic [C_ADDR_WIDTH-1:0] m_address,
  input  logic [C_DATA_WIDTH-1:0] m_data,
  input  logic                    m_data_valid,
  output logic                    owner,
  output logic                    busy,
  output logic                    err_stray_beat
);

  localparam logic [C_LEN_WIDTH:0] CNT_ONE = {{C_LEN_WIDTH{1'b0}}, 1'b1};

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic                    r_owner;
  logic                    r_m_req;
  logic                    r_busy;
  logic                    r_err;
  logic [C_LEN_WIDTH-1:0]  r_arlen;
  logic [C_ADDR_WIDTH-1:0] r_address;
  logic [C_LEN_WIDTH:0]    r_beat_cnt;

  logic [1:0]              w_req;
  logic                    w_any;
  logic                    w_win;
  logic                    w_last_owner;
  logic                    w_accept;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_stray;
  logic [C_LEN_WIDTH:0]    w_cur_cnt;

  assign w_req = {r1_req, r0_req};

  bde_arb_pick u_pick (
    .i_req        (w_req),
    .i_last_owner (w_last_owner),
    .o_any        (w_any),
    .o_win        (w_win)
  );

`ifdef BDE_RD_ARB_RR_EN
  logic r_last_owner;

  always_ff @(posedge clk_axi or posedge reset_axi) begin
    if (reset_axi) begin
      r_last_owner <= 1'b0;
    end else if (r_state == IDLE && w_any) begin
      r_last_owner <= w_win;
    end
  end

  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = 1'b0;
`endif

  // A beat landing together with m_ack is beat 0 of the burst, so the count
  // seen by the last-beat compare is zero in REQ.
  assign w_accept    = (r_state == REQ) && m_ack;
  assign w_beat      = m_data_valid && (w_accept || r_state == DATA);
  assign w_cur_cnt   = (r_state == DATA) ? r_beat_cnt : '0;
  assign w_last_beat = w_beat && (w_cur_cnt == {1'b0, r_arlen});
  assign w_stray     = m_data_valid && !w_beat;

  always_ff @(posedge clk_axi or posedge reset_axi) begin
    if (reset_axi) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = REQ;
      REQ:  if (m_ack) w_state_nxt = w_last_beat ? IDLE : DATA;
      DATA: if (w_last_beat) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r0_ack        = w_accept && (r_owner == REQ_DISP);
    r1_ack        = w_accept && (r_owner == REQ_AUX);
    r0_data_valid = w_beat && (r_owner == REQ_DISP);
    r1_data_valid = w_beat && (r_owner == REQ_AUX);
    r0_data       = m_data;
    r1_data       = m_data;
  end

  always_ff @(posedge clk_axi or posedge reset_axi) begin
    if (reset_axi) begin
      r_owner    <= 1'b0;
      r_m_req    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_arlen    <= '0;
      r_address  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      if (w_stray) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner   <= w_win;
            r_arlen   <= w_win ? r1_arlen : r0_arlen;
            r_address <= w_win ? r1_address : r0_address;
            r_m_req   <= 1'b1;
          end
        end
        REQ: begin
          if (m_ack) begin
            r_m_req    <= 1'b0;
            r_beat_cnt <= w_beat ? CNT_ONE : '0;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CNT_ONE;
          end
        end
        default: r_m_req <= 1'b0;
      endcase
    end
  end

  assign m_req          = r_m_req;
  assign m_arlen        = r_arlen;
  assign m_address      = r_address;
  assign owner          = r_owner;
  assign busy           = r_busy;
  assign err_stray_beat = r_err;

endmodule

// File: tb/tb_bde_rd_arbiter.sv
// Bench for bde_rd_arbiter: directed steps plus randomized bursts against a transaction-level model.
// Works with or without BDE_RD_ARB_RR_EN defined.
module tb_bde_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk_axi;
  logic          reset_axi;
  logic [1:0]    rq;
  logic [LW-1:0] rlen  [2];
  logic [AW-1:0] raddr [2];

  logic          r0_ack, r1_ack, r0_data_valid, r1_data_valid;
  logic [DW-1:0] r0_data, r1_data;
  logic          m_req, m_ack, m_data_valid;
  logic [LW-1:0] m_arlen;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data;
  logic          owner, busy, err_stray_beat;

  int nvec = 0;
  int nerr = 0;
  int n_own, n_oth;
  bit lo;

  bde_rd_arbiter dut (
    .clk_axi        (clk_axi),
    .reset_axi      (reset_axi),
    .r0_req         (rq[0]),
    .r0_ack         (r0_ack),
    .r0_arlen       (rlen[0]),
    .r0_address     (raddr[0]),
    .r0_data        (r0_data),
    .r0_data_valid  (r0_data_valid),
    .r1_req         (rq[1]),
    .r1_ack         (r1_ack),
    .r1_arlen       (rlen[1]),
    .r1_address     (raddr[1]),
    .r1_data        (r1_data),
    .r1_data_valid  (r1_data_valid),
    .m_req          (m_req),
    .m_ack          (m_ack),
    .m_arlen        (m_arlen),
    .m_address      (m_address),
    .m_data         (m_data),
    .m_data_valid   (m_data_valid),
    .owner          (owner),
    .busy           (busy),
    .err_stray_beat (err_stray_beat)
  );

  initial clk_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: single request wins; collision goes to r0
  // in fixed priority, or to the requester that did not own the last burst.
  function automatic int pick_model(input logic [1:0] p, input bit last);
    if (p == 2'b01) return 0;
    if (p == 2'b10) return 1;
`ifdef BDE_RD_ARB_RR_EN
    return last ? 0 : 1;
`else
    return (last && 1'b0) ? 1 : 0;
`endif
  endfunction

  function automatic logic dv_of(input int i);
    return (i == 1) ? r1_data_valid : r0_data_valid;
  endfunction

  function automatic logic ack_of(input int i);
    return (i == 1) ? r1_ack : r0_ack;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int i, input logic [LW-1:0] len, input logic [AW-1:0] a);
    rq[i]    = 1'b1;
    rlen[i]  = len;
    raddr[i] = a;
  endtask

  task automatic chk_dv(input int own, input bit exp_dv);
    chk("dv_owner", 64'(dv_of(own)), 64'(exp_dv));
    chk("dv_other", 64'(dv_of(1 - own)), 64'(0));
    if (dv_of(own) === 1'b1) n_own++;
    if (dv_of(1 - own) === 1'b1) n_oth++;
    if (exp_dv) chk("beat_data", (own == 1) ? r1_data : r0_data, m_data);
  endtask

  task automatic chk_grant(input int own);
    chk("grant_mreq", 64'(m_req), 64'(1));
    chk("grant_addr", 64'(m_address), 64'(raddr[own]));
    chk("grant_len", 64'(m_arlen), 64'(rlen[own]));
    chk("grant_owner", 64'(owner), 64'(own));
    chk("grant_busy", 64'(busy), 64'(1));
  endtask

  // Called in an idle cycle with requests already driven; returns in the
  // idle cycle that follows the burst's last beat.
  task automatic burst(input int own, input int ack_dly, input bit boa,
                       input int max_gap, input bit stray);
    int left;
    int len;
    len   = int'(rlen[own]);
    n_own = 0;
    n_oth = 0;
    settle();
    chk("idle_mreq", 64'(m_req), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_ack0", 64'(r0_ack), 64'(0));
    chk("idle_ack1", 64'(r1_ack), 64'(0));
    tick();
    lo = (own == 1);
    for (int d = 0; d < ack_dly; d++) begin
      m_data_valid = stray && (d == 0);
      m_data       = rnd64();
      settle();
      chk_grant(own);
      chk("wait_ack0", 64'(r0_ack), 64'(0));
      chk("wait_ack1", 64'(r1_ack), 64'(0));
      chk_dv(own, 1'b0);
      tick();
      m_data_valid = 1'b0;
    end
    m_ack        = 1'b1;
    m_data_valid = boa;
    m_data       = rnd64();
    settle();
    chk_grant(own);
    chk("ack_owner", 64'(ack_of(own)), 64'(1));
    chk("ack_other", 64'(ack_of(1 - own)), 64'(0));
    chk_dv(own, boa);
    tick();
    m_ack        = 1'b0;
    m_data_valid = 1'b0;
    rq[own]      = 1'b0;
    left = len + 1 - int'(boa);
    while (left > 0) begin
      repeat ($urandom_range(0, max_gap)) begin
        settle();
        chk("gap_busy", 64'(busy), 64'(1));
        chk("gap_mreq", 64'(m_req), 64'(0));
        chk_dv(own, 1'b0);
        tick();
      end
      m_data_valid = 1'b1;
      m_data       = rnd64();
      settle();
      chk_dv(own, 1'b1);
      chk("beat_ack_other", 64'(ack_of(1 - own)), 64'(0));
      tick();
      m_data_valid = 1'b0;
      left--;
    end
    chk("beats_owner", 64'(n_own), 64'(len + 1));
    chk("beats_other", 64'(n_oth), 64'(0));
  endtask

  initial begin
    int w;
    int tot;
    reset_axi    = 1'b1;
    rq           = 2'b00;
    rlen[0]      = '0;
    rlen[1]      = '0;
    raddr[0]     = '0;
    raddr[1]     = '0;
    m_ack        = 1'b0;
    m_data_valid = 1'b0;
    m_data       = '0;
    lo           = 1'b0;
    #12;
    chk("rst_mreq", 64'(m_req), 64'(0));
    chk("rst_arlen", 64'(m_arlen), 64'(0));
    chk("rst_addr", 64'(m_address), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_stray_beat), 64'(0));
    chk("rst_ack", 64'({r1_ack, r0_ack}), 64'(0));
    chk("rst_dv", 64'({r1_data_valid, r0_data_valid}), 64'(0));
    tick();
    reset_axi = 1'b0;
    tick();

    // Single r0 burst of 16 beats, ack three cycles after m_req.
    set_req(0, 8'h0F, 32'h1780_0000);
    burst(pick_model(rq, lo), 3, 1'b0, 0, 1'b0);

    // Simultaneous requests: winner by rule, then the loser.
    set_req(0, 8'h07, 32'h1790_0000);
    set_req(1, 8'h07, 32'h1800_0000);
    w = pick_model(rq, lo);
    burst(w, 1, 1'b0, 1, 1'b0);
    burst(pick_model(rq, lo), 0, 1'b1, 1, 1'b0);

    // Single-beat burst with the beat coincident with m_ack.
    set_req(1, 8'h00, 32'h1800_1000);
    burst(pick_model(rq, lo), 2, 1'b1, 0, 1'b0);
    settle();
    chk("len0_idle", 64'(busy), 64'(0));
    tick();

    // Stray beat while idle.
    m_data_valid = 1'b1;
    m_data       = rnd64();
    settle();
    chk_dv(0, 1'b0);
    chk("stray_err_pre", 64'(err_stray_beat), 64'(0));
    tick();
    m_data_valid = 1'b0;
    settle();
    chk("stray_err_set", 64'(err_stray_beat), 64'(1));
    tick();
    tick();
    settle();
    chk("stray_err_hold", 64'(err_stray_beat), 64'(1));
    tick();

    // Randomized request mixes.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && $urandom_range(0, 2) != 0)
          set_req(i, LW'($urandom_range(0, 15)), $urandom);
      end
      if (rq == 2'b00) set_req(int'($urandom_range(0, 1)), LW'($urandom_range(0, 15)), $urandom);
      burst(pick_model(rq, lo), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, 1'b0);
    end
    if (rq != 2'b00) burst(pick_model(rq, lo), 1, 1'b0, 1, 1'b0);

    // Back-to-back full-length r0 bursts.
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 8'hFF, 32'h1900_0000 + AW'(k) * 32'h800);
      burst(pick_model(rq, lo), 0, 1'b0, 0, 1'b0);
      tot += n_own;
    end
    chk("b2b_total", 64'(tot), 64'(1024));
    settle();
    chk("err_sticky", 64'(err_stray_beat), 64'(1));

    // Reset in the middle of a 256-beat r1 burst.
    tick();
    set_req(1, 8'hFF, 32'h1A00_0000);
    tick();
    m_ack        = 1'b1;
    m_data_valid = 1'b1;
    m_data       = rnd64();
    settle();
    chk_dv(1, 1'b1);
    tick();
    m_ack = 1'b0;
    rq[1] = 1'b0;
    for (int b = 2; b <= 5; b++) begin
      settle();
      chk_dv(1, 1'b1);
      tick();
    end
    settle();
    chk("mid_owner", 64'(owner), 64'(1));
    chk("mid_busy", 64'(busy), 64'(1));
    reset_axi = 1'b1;
    #1;
    chk("arst_mreq", 64'(m_req), 64'(0));
    chk("arst_arlen", 64'(m_arlen), 64'(0));
    chk("arst_addr", 64'(m_address), 64'(0));
    chk("arst_owner", 64'(owner), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_err", 64'(err_stray_beat), 64'(0));
    chk("arst_dv1", 64'(r1_data_valid), 64'(0));
    m_data_valid = 1'b0;
    tick();
    tick();
    reset_axi = 1'b0;
    lo        = 1'b0;
    tick();

    // Fresh r1 burst after reset, with a stray beat while waiting for m_ack.
    set_req(1, 8'h03, 32'h1800_0040);
    burst(pick_model(rq, lo), 1, 1'b0, 1, 1'b1);
    settle();
    chk("req_stray_err", 64'(err_stray_beat), 64'(1));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bde_rd_arbiter.md
Name: bde_rd_arbiter

Overview:
Two-requester read arbiter that shares the single bitmap-engine read port (req/ack/arlen/address, data/data_valid) of the AXI4 master interface.
- Requester 0 is the bitmap display engine (real-time).
- Requester 1 is a secondary frame-buffer reader, e.g. the HOG feature fetch.
- Exactly one burst is outstanding at a time. Read data is routed back to the requester that owns the burst.
- Sits between the requesters and the AXI master interface, entirely in the clk_axi domain.

Parameters:
C_ADDR_WIDTH, 32, byte address width of requests
C_DATA_WIDTH, 64, read data beat width
C_LEN_WIDTH, 8, burst length field width (AXI ARLEN encoding: beats-1)

Ports:
clk_axi  in  1  AXI clock; all logic on rising edge
reset_axi  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 burst request, level, held until r0_ack
r0_ack  out  1  one-cycle acknowledge to requester 0
r0_arlen  in  C_LEN_WIDTH  requester 0 burst length-1, stable while r0_req
r0_address  in  C_ADDR_WIDTH  requester 0 start address, stable while r0_req
r0_data  out  C_DATA_WIDTH  read data to requester 0
r0_data_valid  out  1  read beat valid for requester 0
r1_req, r1_ack, r1_arlen, r1_address, r1_data, r1_data_valid  same as r0_* for requester 1
m_req  out  1  request to AXI master interface
m_ack  in  1  one-cycle acknowledge from AXI master interface
m_arlen  out  C_LEN_WIDTH  forwarded burst length
m_address  out  C_ADDR_WIDTH  forwarded address
m_data  in  C_DATA_WIDTH  read data from AXI master interface
m_data_valid  in  1  read beat valid
owner  out  1  current or last burst owner
busy  out  1  high whenever state is not IDLE
err_stray_beat  out  1  sticky flag: beat received while no burst is owned

Behaviour:
- Reset values:
  - Registered outputs 0: m_req, m_arlen, m_address, owner, busy, err_stray_beat, round-robin pointer.
  - State IDLE.
  - rN_ack and rN_data_valid are combinational, so they are 0 whenever state is IDLE.
- IDLE:
  - If any rN_req is high, the arbiter selects a winner (fixed priority: r0 over r1).
  - It latches owner, arlen_q <= rN_arlen and m_address <= rN_address.
  - m_req goes high next cycle. State -> REQ.
  - Latency from rN_req high to m_req high is 1 cycle.
- REQ:
  - m_req is held high with stable m_address/m_arlen until m_ack.
  - rN_ack = m_ack & (state==REQ) & (owner==N). The ack is combinational, same cycle as m_ack.
  - On m_ack: m_req <= 0, beat_cnt <= 0, state -> DATA.
  - A requester's req changing while it is not acked is ignored; its inputs were already latched.
- DATA:
  - rN_data = m_data for both requesters (broadcast).
  - rN_data_valid = m_data_valid & (owner==N) & (state in REQ-with-m_ack, or DATA).
  - Each beat increments beat_cnt (C_LEN_WIDTH+1 bits).
  - On the beat where beat_cnt==arlen_q: state -> IDLE.
  - A new grant can be latched in the next cycle, so there is a minimum 1 idle cycle between bursts.
- Beat coincident with m_ack: counted as beat 0 for the owner. If arlen_q==0, state goes straight to IDLE.
- Stray beat: m_data_valid in IDLE, or in REQ without m_ack.
  - The beat is dropped: no rN_data_valid.
  - err_stray_beat <= 1. It clears only on reset.
- Simultaneous requests: the winner is granted. The loser keeps req high and is granted at the next IDLE.
- Starvation: r1 can starve under continuous r0 in fixed-priority mode. This is accepted; the display engine has priority.
- Reset mid-burst: everything returns to IDLE immediately and the in-flight burst is abandoned. The AXI master interface shares the same reset source and is reset with it.

Optional Feature:
BDE_RD_ARB_RR_EN
- Defined: round-robin arbitration.
  - A 1-bit last-owner pointer updates on every grant.
  - On a simultaneous request, the requester that is not last-owner wins.
  - A single request always wins.
- Undefined: fixed priority r0 > r1. The pointer logic is absent.

Decomposition:
- Package bde_arb_pkg holds:
  - state enum {IDLE, REQ, DATA}
  - localparam defaults for address/data/len widths
  - requester index constants REQ_DISP=0, REQ_AUX=1
- One sub-module, bde_arb_pick: a combinational winner select from req[1:0] and last_owner, covering both the RR and fixed-priority variants.
- The FSM and beat counter stay in the top level.

Test Plan:
- r0_req with address 0x17800000, arlen 0x0F; m_ack 3 cycles later; 16 beats:
  - m_req rises 1 cycle after r0_req, with m_address 0x17800000 and m_arlen 0x0F.
  - r0_ack pulses with m_ack.
  - 16 r0_data_valid pulses, 0 on r1.
  - busy drops after beat 16.
- r0_req and r1_req in the same cycle, both arlen 0x07:
  - Without RR: r0 is served first, then r1 (r1 at address 0x18000000 appears on m_address after r0's 8th beat + 1 cycle).
  - With BDE_RD_ARB_RR_EN and last owner 0: r1 is served first.
- arlen 0x00 with m_data_valid asserted in the same cycle as m_ack: a single r1_data_valid pulse, and state returns to IDLE the next cycle.
- m_data_valid pulse while idle: no rN_data_valid, err_stray_beat = 1 and stays 1 until reset_axi.
- reset_axi asserted after beat 5 of a 256-beat burst (arlen 0xFF): all outputs 0 asynchronously. After release, a new r1_req is granted normally.
- Back-to-back r0 bursts, 4 × arlen 0xFF: exactly 1024 r0 beats; the m_req gap between bursts is ≥1 cycle; r1 never acked.
